// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the uart_bridge slice
// Holds the TX/RX state enums, the default bit period and the 8N1 frame sizes.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned FRAME_BITS           = 10;   // start + 8 data + stop

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_bridge_if.sv
// rtl/uart_bridge_if.sv - controller-side strobe/status bundle of the UART
// Signals:
//   rdn, wrn      read / write strobes, active low (controller -> UART)
//   data_ready    RBR holds an unread byte        (UART -> controller)
//   tbre          transmit holding register empty (UART -> controller)
//   tsre          THR empty and shifter idle      (UART -> controller)
// The shared 8-bit data bus stays a plain inout on the UART because it is a
// resolved tri-state net driven from both ends.
interface uart_bridge_if;

  logic rdn;
  logic wrn;
  logic data_ready;
  logic tbre;
  logic tsre;

  modport master (
    output rdn,
    output wrn,
    input  data_ready,
    input  tbre,
    input  tsre
  );

  modport slave (
    input  rdn,
    input  wrn,
    output data_ready,
    output tbre,
    output tsre
  );

endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: synchronizer, RX FSM and bit counter
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rxd_i          asynchronous serial input, idle high
//   byte_valid_o   one-cycle strobe, a frame with a good stop bit completed
//   byte_o         received byte, valid while byte_valid_o is high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0] rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;

  logic             fall_edge;
  logic             mid_done;
  logic             bit_done;

  // rxd_prev_q only serves edge detection; it never feeds the sampled data.
  assign fall_edge = rxd_prev_q & ~rxd_sync_q;
  assign mid_done  = (rx_cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_done  = (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q   <= 1'b1;
      rxd_sync_q   <= 1'b1;
      rxd_prev_q   <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rxd_meta_q   <= rxd_i;
      rxd_sync_q   <= rxd_meta_q;
      rxd_prev_q   <= rxd_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_W'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (fall_edge) begin
          rx_state_d = RX_START;
        end
      end

      // Half a bit in: a real start bit is still low, a glitch is not.
      RX_START: begin
        if (mid_done) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end
      end

      // Counting restarts at mid-start, so each full period lands mid-bit.
      RX_DATA: begin
        if (bit_done) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end

      // A low stop bit drops the byte; the line must go high and fall again.
      RX_STOP: begin
        if (bit_done) begin
          rx_cnt_d     = '0;
          byte_valid_d = rxd_sync_q;
          rx_state_d   = RX_IDLE;
        end
      end

      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = rx_shift_q;

endmodule

// File: rtl/uart_bridge.sv
// rtl/uart_bridge.sv - device end of the rdn/wrn UART interface, 8N1 TX and RX
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   bus        strobes in (rdn, wrn), status out (data_ready, tbre, tsre)
//   data       shared 8-bit bus, driven with RBR while rdn is low
//   txd        serial out, idle high
//   rxd        serial in, asynchronous
module uart_bridge
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  uart_bridge_if.slave    bus,
  inout  wire  [7:0]      data,
  output logic            txd,
  input  logic            rxd
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  // Bus sampling and strobe history
  logic [7:0]       bus_q;
  logic             wrn_q, rdn_q;
  logic             wr_acc, rd_fall, rd_rise;

  // Transmit side
  logic [7:0]       thr_q, thr_d;
  logic             tbre_q, tbre_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;
  logic             tx_bit_done;
  logic             load_shifter;

  // Receive side
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic [7:0]       rbr_q, rbr_d;
  logic             data_ready_q, data_ready_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             rd_acc_q, rd_acc_d;

  assign wr_acc  = wrn_q & ~bus.wrn;
  assign rd_fall = rdn_q & ~bus.rdn;
  assign rd_rise = ~rdn_q & bus.rdn;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rxd_i        (rxd),
    .byte_valid_o (byte_valid),
    .byte_o       (rx_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q        <= '0;
      wrn_q        <= 1'b1;
      rdn_q        <= 1'b1;
      thr_q        <= '0;
      tbre_q       <= 1'b1;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      txd_q        <= 1'b1;
      rbr_q        <= '0;
      data_ready_q <= 1'b0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      rd_acc_q     <= 1'b0;
    end else begin
      bus_q        <= data;
      wrn_q        <= bus.wrn;
      rdn_q        <= bus.rdn;
      thr_q        <= thr_d;
      tbre_q       <= tbre_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      txd_q        <= txd_d;
      rbr_q        <= rbr_d;
      data_ready_q <= data_ready_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      rd_acc_q     <= rd_acc_d;
    end
  end

  // TX FSM. tx_bit_q is the frame bit on the line: 0 start, 1..8 data.
  assign tx_bit_done = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + CNT_W'(1);
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    txd_d        = txd_q;
    thr_d        = thr_q;
    tbre_d       = tbre_q;
    load_shifter = 1'b0;

    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d     = '0;
        load_shifter = ~tbre_q;
      end

      TX_START: begin
        if (tx_bit_done) begin
          tx_cnt_d   = '0;
          tx_bit_d   = BIT_W'(1);
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end
      end

      TX_DATA: begin
        if (tx_bit_done) begin
          tx_cnt_d = '0;
          if (tx_bit_q == BIT_W'(DATA_BITS)) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + BIT_W'(1);
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end

      // A byte already waiting in THR starts its frame without an idle bit.
      TX_STOP: begin
        if (tx_bit_done) begin
          tx_cnt_d = '0;
          if (!tbre_q) begin
            load_shifter = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end

      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
        txd_d      = 1'b1;
      end
    endcase

    if (load_shifter) begin
      tx_state_d = TX_START;
      tx_shift_d = thr_q;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      txd_d      = 1'b0;
      tbre_d     = 1'b1;
    end

    // THR can only be loaded while empty, so this never races the move above.
    if (wr_acc && tbre_q) begin
      thr_d  = bus_q;
      tbre_d = 1'b0;
    end
  end

  // RBR / pending logic. A byte finishing under an active read is parked so
  // the value on the bus stays stable for the whole strobe.
  always_comb begin
    rbr_d        = rbr_q;
    data_ready_d = data_ready_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    rd_acc_d     = rd_acc_q;

    if (rd_fall) begin
      rd_acc_d = data_ready_q;
    end

    if (rd_rise) begin
      rd_acc_d = 1'b0;
      if (rd_acc_q) begin
        data_ready_d = 1'b0;
      end
      if (pend_v_q) begin
        rbr_d        = pend_q;
        data_ready_d = 1'b1;
        pend_v_d     = 1'b0;
      end
    end

    // Newest byte wins over a pending commit in the same cycle.
    if (byte_valid) begin
      if (bus.rdn) begin
        rbr_d        = rx_byte;
        data_ready_d = 1'b1;
      end else begin
        pend_d   = rx_byte;
        pend_v_d = 1'b1;
      end
    end
  end

  assign data            = bus.rdn ? 8'hzz : rbr_q;
  assign txd             = txd_q;
  assign bus.tbre        = tbre_q;
  assign bus.tsre        = tbre_q & (tx_state_q == TX_IDLE);
  assign bus.data_ready  = data_ready_q;

endmodule
